// File: rtl/anim_pkg.sv
// Shared types and raster constants for the sprite animation path.
package anim_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } anim_state_t;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int NUM_FRAMES = 4;

endpackage

// File: rtl/anim_sequencer_if.sv
// Raster inputs, animation controls and display-state outputs of the sequencer.
interface anim_sequencer_if #(
  parameter int FRAME_W = 2
);

  logic [9:0]         hpos;
  logic [9:0]         vpos;
  logic               run;
  logic               hold;
  logic               step;
  logic               pingpong;
  logic [2:0]         speed;
  logic [FRAME_W-1:0] frame_sel;
  logic [9:0]         x_off;
  logic               facing;
  logic               frame_tick;
  logic [1:0]         state;

  modport master (
    output hpos, vpos, run, hold, step, pingpong, speed,
    input  frame_sel, x_off, facing, frame_tick, state
  );

  modport slave (
    input  hpos, vpos, run, hold, step, pingpong, speed,
    output frame_sel, x_off, facing, frame_tick, state
  );

endinterface

// File: rtl/anim_bounce.sv
// Sprite window x offset that bounces between 0 and X_MAX, one step per enabled tick.
module anim_bounce #(
  parameter int X_MAX   = 384,
  parameter int STEP_PX = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_en,
  input  logic       clear,
  output logic [9:0] x_off,
  output logic       facing
);

  localparam logic [10:0] STEP11 = 11'(STEP_PX);
  localparam logic [9:0]  STEP10 = 10'(STEP_PX);
  localparam logic [9:0]  XMAX10 = 10'(X_MAX);

  logic [9:0]  x_q, x_d;
  logic        facing_q, facing_d;
  logic [10:0] sum;

  always_comb begin
    x_d      = x_q;
    facing_d = facing_q;
    sum      = {1'b0, x_q} + STEP11;
    if (clear) begin
      x_d      = '0;
      facing_d = 1'b0;
    end else if (tick_en) begin
      if (!facing_q) begin
        // 11-bit sum so the edge compare cannot wrap near 1023
        if (sum >= {1'b0, XMAX10}) begin
          x_d      = XMAX10;
          facing_d = 1'b1;
        end else begin
          x_d = sum[9:0];
        end
      end else begin
        if ({1'b0, x_q} <= STEP11) begin
          x_d      = '0;
          facing_d = 1'b0;
        end else begin
          x_d = x_q - STEP10;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      facing_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      facing_q <= facing_d;
    end
  end

  assign x_off  = x_q;
  assign facing = facing_q;

endmodule

// File: rtl/anim_sequencer.sv
// Animation frame / sprite position controller; all display updates land at vblank start.
//
// state | meaning
// STOP  | idle; next tick homes frame, position and divider
// RUN   | animate: divider-paced frame advance, position moves every tick
// HOLD  | frozen; each tick with a pending step edge gives one frame advance
module anim_sequencer
  import anim_pkg::*;
#(
  parameter int NUM_FRAMES = anim_pkg::NUM_FRAMES,
  parameter int FRAME_W    = 2,
  parameter int H_ACTIVE   = anim_pkg::H_ACTIVE,
  parameter int V_ACTIVE   = anim_pkg::V_ACTIVE,
  parameter int X_MAX      = 384,
  parameter int STEP_PX    = 2
) (
  input logic             clk,
  input logic             rst_n,
  anim_sequencer_if.slave bus
);

  if ((NUM_FRAMES < 1) || (NUM_FRAMES > 16) || ((1 << FRAME_W) < NUM_FRAMES) ||
      (H_ACTIVE < 1) || (V_ACTIVE < 1) || (X_MAX > 1023)) begin : g_bad_cfg
    $error("anim_sequencer: inconsistent parameters");
  end

  localparam logic [FRAME_W-1:0] LAST = FRAME_W'(NUM_FRAMES - 1);

  anim_state_t        state_q, state_d;
  logic               frame_tick_q, frame_tick_d;
  logic [FRAME_W-1:0] frame_sel_q, frame_sel_d;
  logic               dir_down_q, dir_down_d;
  logic [2:0]         div_cnt_q, div_cnt_d;
  logic               step_q, step_d;
  logic               step_pend_q, step_pend_d;
  logic               advance;
  logic               step_rise;
  logic               tick_raw;
  logic [FRAME_W-1:0] nxt_frame;
  logic               nxt_dir_down;

  assign tick_raw  = (bus.vpos == 10'(V_ACTIVE)) && (bus.hpos == 10'd0);
  assign step_rise = bus.step & ~step_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOP:    if (bus.run) state_d = RUN;
      RUN:     if (!bus.run) state_d = STOP; else if (bus.hold) state_d = HOLD;
      HOLD:    if (!bus.run) state_d = STOP; else if (!bus.hold) state_d = RUN;
      default: state_d = STOP;
    endcase
  end

  always_comb begin
    nxt_frame    = frame_sel_q;
    nxt_dir_down = 1'b0;
    if (NUM_FRAMES == 1) begin
      nxt_frame = '0;
    end else if (!bus.pingpong) begin
      nxt_frame = (frame_sel_q == LAST) ? '0 : frame_sel_q + 1'b1;
    end else if (!dir_down_q) begin
      nxt_dir_down = (frame_sel_q == LAST);
      nxt_frame    = nxt_dir_down ? frame_sel_q - 1'b1 : frame_sel_q + 1'b1;
    end else begin
      nxt_dir_down = (frame_sel_q != '0);
      nxt_frame    = nxt_dir_down ? frame_sel_q - 1'b1 : frame_sel_q + 1'b1;
    end
  end

  // Tick actions key off state_q so a same-cycle transition sees the old state.
  always_comb begin
    frame_tick_d = tick_raw;
    step_d       = bus.step;
    frame_sel_d  = frame_sel_q;
    dir_down_d   = dir_down_q;
    div_cnt_d    = div_cnt_q;
    step_pend_d  = step_pend_q;
    advance      = 1'b0;
    if (frame_tick_q) begin
      case (state_q)
        STOP: begin
          frame_sel_d = '0;
          dir_down_d  = 1'b0;
          div_cnt_d   = '0;
        end
        RUN: begin
          if (div_cnt_q >= bus.speed) begin
            advance   = 1'b1;
            div_cnt_d = '0;
          end else begin
            div_cnt_d = div_cnt_q + 3'd1;
          end
        end
        HOLD: begin
          if (step_pend_q) begin
            advance     = 1'b1;
            step_pend_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
    if (step_rise && state_q == HOLD) step_pend_d = 1'b1;
    if (state_d != HOLD) step_pend_d = 1'b0;
    if (advance) begin
      frame_sel_d = nxt_frame;
      dir_down_d  = nxt_dir_down;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= STOP;
      frame_tick_q <= 1'b0;
      frame_sel_q  <= '0;
      dir_down_q   <= 1'b0;
      div_cnt_q    <= '0;
      step_q       <= 1'b0;
      step_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_tick_q <= frame_tick_d;
      frame_sel_q  <= frame_sel_d;
      dir_down_q   <= dir_down_d;
      div_cnt_q    <= div_cnt_d;
      step_q       <= step_d;
      step_pend_q  <= step_pend_d;
    end
  end

  anim_bounce #(
    .X_MAX   (X_MAX),
    .STEP_PX (STEP_PX)
  ) u_bounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_en (frame_tick_q && (state_q == RUN)),
    .clear   (frame_tick_q && (state_q == STOP)),
    .x_off   (bus.x_off),
    .facing  (bus.facing)
  );

  assign bus.frame_sel  = frame_sel_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Directed bench for anim_sequencer with a compressed raster: each frame is a few clocks.
module tb_anim_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  anim_sequencer_if #(.FRAME_W(2)) bus ();

  anim_sequencer #(
    .NUM_FRAMES (4),
    .FRAME_W    (2),
    .H_ACTIVE   (640),
    .V_ACTIVE   (480),
    .X_MAX      (384),
    .STEP_PX    (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raster hits (hpos=0, vpos=480) for one clock; frame_tick follows one clock later.
  task automatic tick(input bit step_now = 1'b0);
    bus.vpos = 10'd480;
    bus.hpos = 10'd0;
    cyc(1);
    check("frame_tick_hi", bus.frame_tick, 1);
    bus.vpos = 10'd100;
    bus.hpos = 10'd7;
    if (step_now) bus.step = 1'b1;
    cyc(1);
    check("frame_tick_lo", bus.frame_tick, 0);
    cyc(2);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int loop_exp[10];
    int pp_exp[14];
    loop_exp = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
    pp_exp   = '{0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0, 0, 1};

    bus.hpos = 10'd0;
    bus.vpos = 10'd0;
    bus.run = 1'b0;
    bus.hold = 1'b0;
    bus.step = 1'b0;
    bus.pingpong = 1'b0;
    bus.speed = 3'd0;
    cyc(2);
    check("rst_state", bus.state, 0);
    check("rst_frame", bus.frame_sel, 0);
    check("rst_xoff", bus.x_off, 0);
    check("rst_facing", bus.facing, 0);
    check("rst_tick", bus.frame_tick, 0);
    rst_n = 1'b1;
    cyc(2);

    // loop mode, advance every tick
    bus.run = 1'b1;
    cyc(1);
    check("run_state", bus.state, 1);
    check("run_pre_frame", bus.frame_sel, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("loop_frame%0d", i), bus.frame_sel, loop_exp[i]);
    end
    check("loop_xoff", bus.x_off, 20);
    check("loop_facing", bus.facing, 0);
    tick();
    check("loop_frame3", bus.frame_sel, 3);

    // run dropped mid-frame: state leaves at once, display waits for the tick
    bus.run = 1'b0;
    cyc(1);
    check("stop_state", bus.state, 0);
    check("stop_hold_frame", bus.frame_sel, 3);
    cyc(3);
    check("stop_hold_frame2", bus.frame_sel, 3);
    check("stop_hold_xoff", bus.x_off, 22);
    tick();
    check("stop_home_frame", bus.frame_sel, 0);
    check("stop_home_xoff", bus.x_off, 0);
    check("stop_home_facing", bus.facing, 0);

    // pingpong, advance every 2nd tick
    bus.pingpong = 1'b1;
    bus.speed = 3'd1;
    bus.run = 1'b1;
    cyc(1);
    for (int i = 0; i < 14; i++) begin
      tick();
      check($sformatf("pp_frame%0d", i), bus.frame_sel, pp_exp[i]);
    end
    check("pp_xoff", bus.x_off, 28);

    // divider above a newly reduced speed advances on the next tick
    bus.speed = 3'd3;
    tick();
    check("spd_frame_a", bus.frame_sel, 1);
    tick();
    check("spd_frame_b", bus.frame_sel, 1);
    bus.speed = 3'd0;
    tick();
    check("spd_frame_c", bus.frame_sel, 2);
    check("spd_xoff", bus.x_off, 34);

    // bounce at X_MAX and at 0
    ticks(174);
    check("bnc_382", bus.x_off, 382);
    check("bnc_382_facing", bus.facing, 0);
    tick();
    check("bnc_384", bus.x_off, 384);
    check("bnc_384_facing", bus.facing, 1);
    tick();
    check("bnc_back_382", bus.x_off, 382);
    tick();
    check("bnc_back_380", bus.x_off, 380);
    ticks(189);
    check("bnc_2", bus.x_off, 2);
    check("bnc_2_facing", bus.facing, 1);
    tick();
    check("bnc_0", bus.x_off, 0);
    check("bnc_0_facing", bus.facing, 0);

    // HOLD with single-step
    bus.run = 1'b0;
    bus.pingpong = 1'b0;
    cyc(1);
    tick();
    bus.run = 1'b1;
    cyc(1);
    tick();
    check("hold_pre_frame", bus.frame_sel, 1);
    check("hold_pre_xoff", bus.x_off, 2);
    bus.hold = 1'b1;
    cyc(1);
    check("hold_state", bus.state, 2);
    for (int i = 0; i < 3; i++) begin
      bus.step = 1'b1;
      cyc(1);
      bus.step = 1'b0;
      cyc(1);
      check("hold_frame_stable", bus.frame_sel, 1);
    end
    tick();
    check("hold_step_frame", bus.frame_sel, 2);
    check("hold_step_xoff", bus.x_off, 2);
    tick();
    check("hold_nostep_frame", bus.frame_sel, 2);
    tick(1'b1);
    bus.step = 1'b0;
    check("hold_step_at_tick", bus.frame_sel, 2);
    tick();
    check("hold_step_next", bus.frame_sel, 3);
    check("hold_xoff_frozen", bus.x_off, 2);
    bus.hold = 1'b0;
    cyc(1);
    check("unhold_state", bus.state, 1);

    // async reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", bus.state, 0);
    check("arst_frame", bus.frame_sel, 0);
    check("arst_xoff", bus.x_off, 0);
    check("arst_facing", bus.facing, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    check("post_rst_state", bus.state, 1);
    cyc(2);
    check("post_rst_frame", bus.frame_sel, 0);
    tick();
    check("post_rst_tick_frame", bus.frame_sel, 1);
    check("post_rst_tick_xoff", bus.x_off, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/anim_sequencer.md
Name: anim_sequencer

Overview:
- Controller for the sprite display datapath: the VGA timing generator, the frame LUTs, the palette and the on-screen shape window.
- Selects which animation frame LUT feeds the palette. Also sets the sprite window's horizontal offset, which bounces left and right, and its facing direction.
- All displayed state changes happen once per video frame at the start of vertical blank, so no frame tears mid-scan.
- Sits between the hvsync generator outputs and the frame-LUT mux / shape-window compare in the top level.

Parameters:
- NUM_FRAMES, 4, number of animation frame LUTs (1..16).
- FRAME_W, 2, width of frame_sel; must satisfy 2**FRAME_W >= NUM_FRAMES.
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- X_MAX, 384, maximum sprite x offset in pixels.
- STEP_PX, 2, x offset change per vblank tick.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- hpos  in  10  current pixel x from the hvsync generator.
- vpos  in  10  current pixel y from the hvsync generator.
- run  in  1  level; 1 = animate, 0 = stop and home.
- hold  in  1  level; freeze the animation while run=1.
- step  in  1  single-advance request while holding; the block edge-detects it internally.
- pingpong  in  1  0 = loop 0..N-1,0,..; 1 = bounce 0..N-1..0.
- speed  in  3  vblank ticks per frame advance, minus 1 (0 = every frame).
- frame_sel  out  FRAME_W  selected frame LUT index.
- x_off  out  10  sprite window x offset.
- facing  out  1  0 = moving right, 1 = moving left.
- frame_tick  out  1  one-cycle pulse at each vblank start.
- state  out  2  STOP=0, RUN=1, HOLD=2.

Behaviour:
- Reset: the async assert of rst_n forces all outputs and internals to 0 immediately: frame_sel=0, x_off=0, facing=0, frame_tick=0, state=STOP, div_cnt=0, anim_dir=up, step_pend=0, step_q=0.
- Tick generation:
  - tick_raw = (vpos==V_ACTIVE && hpos==0).
  - frame_tick is tick_raw registered, so it lags by 1 clk and lasts exactly 1 clk per frame.
  - Every update of frame_sel, x_off and facing happens only in a cycle where frame_tick=1, and takes effect on the following clk edge.
- State machine (transitions are immediate, evaluated every clk; run has priority over hold):
  - STOP: run=1 → RUN.
  - RUN: run=0 → STOP; hold=1 → HOLD.
  - HOLD: run=0 → STOP; hold=0 → RUN.
- STOP on tick: frame_sel<=0, x_off<=0, facing<=0, div_cnt<=0, anim_dir<=up, step_pend<=0.
- RUN on tick:
  - Divider: if div_cnt>=speed then advance the frame and set div_cnt<=0; else div_cnt<=div_cnt+1. A speed change takes effect from the next tick. A div_cnt left above a new, smaller speed causes an advance on the next tick.
  - Position updates on every tick, independent of the divider:
    - facing=0: if x_off+STEP_PX >= X_MAX then x_off<=X_MAX and facing<=1; else x_off+=STEP_PX.
    - facing=1: if x_off <= STEP_PX then x_off<=0 and facing<=0; else x_off-=STEP_PX.
  - Position arithmetic is 11-bit internally; no wrap.
- HOLD:
  - A rising edge of step sets step_pend.
  - On a tick with step_pend=1: one frame advance, then step_pend<=0.
  - Multiple step edges before a tick still produce one advance.
  - Divider and position are frozen.
  - step_pend is cleared on entering RUN or STOP.
- Frame advance rules:
  - Loop (pingpong=0): frame_sel <= (frame_sel==NUM_FRAMES-1) ? 0 : frame_sel+1. anim_dir is forced to up.
  - Pingpong, anim_dir up: if frame_sel==NUM_FRAMES-1 then set anim_dir down and frame_sel-1; else frame_sel+1.
  - Pingpong, anim_dir down: if frame_sel==0 then set anim_dir up and frame_sel+1; else frame_sel-1.
  - NUM_FRAMES=1: frame_sel stays 0 in all modes.
- Simultaneous events:
  - A state change and a tick in the same cycle: the tick action uses the state held before that edge.
  - A step edge in the same cycle as a tick: it sets step_pend for the next tick; it does not advance now.
- frame_sel and x_off are never modified outside tick cycles, so they are constant throughout active video.

Decomposition:
- Shared package anim_pkg holds:
  - state enum anim_state_t {STOP, RUN, HOLD};
  - constants H_ACTIVE, V_ACTIVE and the default NUM_FRAMES, used by the hvsync generator, the frame LUT mux and the top level.
- One sub-module, anim_bounce: the x_off/facing bounce register with inputs tick_en, clear and outputs x_off, facing.
- Divider, frame advance and FSM stay in anim_sequencer.

Test Plan:
- Reset mid-RUN with frame_sel=2, x_off=100 → all outputs are 0 within the same cycle as rst_n falling, and stay 0 until run=1 and the next tick.
- run=1, speed=0, pingpong=0, NUM_FRAMES=4, 10 frames → frame_sel sequence 1,2,3,0,1,2,3,0,1,2. frame_tick occurs once per frame, 1 clk after (hpos=0, vpos=480).
- pingpong=1, speed=1 → frame_sel advances every 2nd tick: 0,1,2,3,2,1,0,1,…
- x_off bounce, X_MAX=384, STEP_PX=2, starting at 382 with facing=0 → next tick gives 384 and facing=1; then 382, 380. From x_off=2 with facing=1 → 0 and facing=0.
- HOLD with 3 step pulses inside one frame → exactly one advance at the next tick. x_off is unchanged, and frame_sel is stable across all of active video.
- run dropped mid-frame with frame_sel=3 → state=STOP next clk. frame_sel stays 3 until the tick, then becomes 0 and x_off becomes 0.
